id_ex_pipe: RTL and testbench
=============================

// Module: id_ex_pipe
// PURPOSE
// - Parametrised ID->EX stage register with valid/ready flow control.
// - Decouples stalls through a 2-entry skid buffer and treats flush separately from stall.
// - Issues the load read request from a registered address with a req/gnt handshake to the RIB bus.
// - Sits between the decoder and the EX unit. A bubble drives the canonical NOP fields.
// PARAMETERS
// DATA_W      32            register/immediate/CSR data width
// ADDR_W      32            instruction and memory address width
// REG_ADDR_W  5             register-file address width
// SKID_EN     1             1: 2-entry skid (full throughput); 0: single entry, id_ready_o=!ex_valid_o|ex_ready_i
// RESET_ADDR  32'h0         ins_addr shown for a bubble
// NOP_INS     32'h00000013  instruction word shown for a bubble (addi x0,x0,0)
// PORTS
// clk            in   1           clock, all state on rising edge
// rst            in   1           synchronous reset, active-high
// flush_i        in   1           kill all held entries (branch/trap)
// id_valid_i     in   1           ID presents a decoded instruction
// id_ready_o     out  1           stage can accept this cycle
// ins_i/ins_addr_i  in  DATA_W/ADDR_W  instruction word / PC
// opcode_i,funct3_i,funct7_i  in  7,3,7  decoded fields
// reg1_rd_data_i,reg2_rd_data_i,imm_i  in  DATA_W  operands
// reg_wr_addr_i  in   REG_ADDR_W  destination register
// csr_rd_data_i,csr_zimm_i  in  DATA_W; csr_rw_addr_i in ADDR_W   CSR fields
// mem_rd_flag_i  in   1           instruction is a load
// ex_valid_o     out  1           EX may consume the head entry
// ex_ready_i     in   1           EX consumes the head entry when ex_valid_o=1
// <field>_o      out  as input    registered head-entry fields, same set as inputs minus mem_rd_flag
// mem_rd_req_o   out  1           load read request to RIB
// mem_rd_addr_o  out  ADDR_W      load address, registered
// mem_rd_gnt_i   in   1           RIB accepts request this cycle
// BEHAVIOUR
// - Reset (rst=1 at edge): both entries invalid; ex_valid_o=0; id_ready_o=1; mem_rd_req_o=0; mem_rd_addr_o=0;
//   outputs=bubble: ins_o=NOP_INS, ins_addr_o=RESET_ADDR, opcode_o=7'b0010011, all other fields 0.
// - Reset mid-operation: in-flight request dropped, no pending state retained.
// - Accept = id_valid_i & id_ready_o. Consume = ex_valid_o & ex_ready_i.
// - Latency: 1 cycle from accept into an empty stage to ex_valid_o (loads: plus the grant wait). Throughput: 1/cycle.
// - id_ready_o = !skid_valid, registered. Never depends combinationally on ex_ready_i when SKID_EN=1.
// - Accept goes to the head if (head empty or consumed) and skid empty; otherwise it goes to skid.
// - On consume with skid valid, skid moves to head in the same edge. Order is strictly preserved.
// - Both entries full, no consume: id_ready_o=0 and the head is held unchanged (stall).
// - flush_i: at that edge both entries become invalid, the head shows the bubble, and the load handshake clears.
//   flush_i wins over a simultaneous accept, consume or grant. An accept in that cycle is discarded.
// - Loads: when a load enters the head, compute mem_rd_addr_o = reg1 + imm, signed, modulo 2^ADDR_W (wrap, no flag).
//   Register the address and assert mem_rd_req_o the next cycle.
//   mem_rd_req_o and mem_rd_addr_o stay stable until mem_rd_gnt_i=1, then req drops and the granted bit is set.
// - ex_valid_o = head_valid & (!head_is_load | granted). A grant and a consume may occur in the same cycle only after granted.
// - A grant arriving with a flush: the bus-side transaction completes, the data is ignored by EX, and no re-request is made.
// - mem_rd_gnt_i while mem_rd_req_o=0 is ignored.
// - Non-load entries never assert mem_rd_req_o. mem_rd_addr_o holds its last value when idle.
// STRUCTURE
// - defines.v: `INS_NOP, `RESET_ADDR, NOP opcode 7'b0010011, ID_EX_PAYLOAD_W (packed field width).
// - Sub-module id_ex_skid #(PAYLOAD_W, SKID_EN): generic 2-entry valid/ready skid with flush, carrying the packed payload.
// - Top level: packing/unpacking, bubble muxing, load request FSM (IDLE->REQ->GNTD->IDLE on consume/flush).
// TESTING
// - Reset: rst=1 for 2 cycles -> ins_o=32'h13, opcode_o=7'h13, ex_valid_o=0, id_ready_o=1, mem_rd_req_o=0.
// - Stream of 8 ALU ops, ex_ready_i=1 -> one out per cycle, 1-cycle latency, fields bit-exact, order kept.
// - ex_ready_i=0 for 3 cycles while ID keeps valid -> 2 entries held, id_ready_o=0 from the 2nd accept, no loss or duplication on release.
// - Load reg1=32'hFFFF_FFF0, imm=32'h20 -> mem_rd_addr_o=32'h10, req held 3 cycles until gnt, ex_valid_o only after the grant.
// - flush_i with both entries full and a simultaneous accept -> next cycle ex_valid_o=0, bubble fields, id_ready_o=1, req=0.
// - flush_i coincident with mem_rd_gnt_i -> req drops, no re-request. rst mid-REQ -> req=0 next cycle.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// rtl/id_ex_pipe_pkg.sv - shared constants, load-request states and payload sizing for id_ex_pipe
// Purpose: bubble constants (NOP instruction, reset address, NOP opcode), the
//          load-request state type and the packed payload width helper.
// Ports:   none (package).
package id_ex_pipe_pkg;

  localparam logic [31:0] INS_NOP        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
  localparam logic [6:0]  NOP_OPCODE     = 7'b0010011;

  typedef enum logic [1:0] {
    LD_IDLE,  // no request outstanding for the head entry
    LD_REQ,   // request on the bus, waiting for grant
    LD_GNTD   // granted, head may be consumed by EX
  } ld_state_t;

  // ins, reg1, reg2, imm, csr_rd, csr_zimm are data wide; ins_addr and
  // csr_rw_addr are address wide; opcode+funct3+funct7+load flag = 18 bits.
  function automatic int payload_w(input int data_w, input int addr_w, input int reg_addr_w);
    return 6 * data_w + 2 * addr_w + reg_addr_w + 18;
  endfunction

endpackage

// File: rtl/id_ex_skid.sv
// rtl/id_ex_skid.sv - generic 2-entry valid/ready skid register with flush
// Purpose: holds a head entry (presented downstream) and an optional skid entry
//          that absorbs one accept while the head is stalled, preserving order.
// Ports:   clk, rst (sync, active-high), flush (drop both entries),
//          in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//          (head entry; out_ready means the head is consumed this cycle).
module id_ex_skid #(
  parameter int PAYLOAD_W = 8,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  logic                 head_valid;
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] head_data;
  logic [PAYLOAD_W-1:0] skid_data;
  logic                 accept;
  logic                 to_head;
  logic                 to_skid;
  logic                 head_load;

  // With the skid enabled, ready is a pure flop output and never looks at
  // out_ready. Without it, the single entry can only refill as it drains.
  assign in_ready  = SKID_EN ? !skid_valid : (!head_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign to_head   = accept && (!head_valid || out_ready) && !skid_valid;
  assign to_skid   = accept && !to_head;
  // A waiting skid entry always has priority over new input: order is kept.
  assign head_load = to_head || (out_ready && skid_valid);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (head_load) begin
        head_valid <= 1'b1;
        head_data  <= skid_valid ? skid_data : in_data;
      end else if (out_ready) begin
        head_valid <= 1'b0;
      end
      if (to_skid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end else if (out_ready && skid_valid) begin
        skid_valid <= 1'b0;
      end
    end
  end

  assign out_valid = head_valid;
  assign out_data  = head_data;

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID->EX stage register with skid buffer, flush and load request handshake
// Purpose: registers decoded instructions between ID and EX with valid/ready
//          flow control, shows a NOP bubble when nothing is offered to EX, and
//          issues the load read request (reg1 + imm) to the RIB bus.
// Ports:   clk, rst (sync, active-high), flush_i;
//          ID side: id_valid_i, id_ready_o, instruction/operand/CSR fields, mem_rd_flag_i;
//          EX side: ex_valid_o, ex_ready_i, the same fields as *_o;
//          RIB side: mem_rd_req_o, mem_rd_addr_o, mem_rd_gnt_i.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                REG_ADDR_W = 5,
  parameter bit                SKID_EN    = 1'b1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF),
  parameter logic [DATA_W-1:0] NOP_INS    = DATA_W'(INS_NOP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [DATA_W-1:0]     ins_i,
  input  logic [ADDR_W-1:0]     ins_addr_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [DATA_W-1:0]     reg1_rd_data_i,
  input  logic [DATA_W-1:0]     reg2_rd_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [REG_ADDR_W-1:0] reg_wr_addr_i,
  input  logic [DATA_W-1:0]     csr_rd_data_i,
  input  logic [DATA_W-1:0]     csr_zimm_i,
  input  logic [ADDR_W-1:0]     csr_rw_addr_i,
  input  logic                  mem_rd_flag_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_W-1:0]     ins_o,
  output logic [ADDR_W-1:0]     ins_addr_o,
  output logic [6:0]            opcode_o,
  output logic [2:0]            funct3_o,
  output logic [6:0]            funct7_o,
  output logic [DATA_W-1:0]     reg1_rd_data_o,
  output logic [DATA_W-1:0]     reg2_rd_data_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic [REG_ADDR_W-1:0] reg_wr_addr_o,
  output logic [DATA_W-1:0]     csr_rd_data_o,
  output logic [DATA_W-1:0]     csr_zimm_o,
  output logic [ADDR_W-1:0]     csr_rw_addr_o,
  output logic                  mem_rd_req_o,
  output logic [ADDR_W-1:0]     mem_rd_addr_o,
  input  logic                  mem_rd_gnt_i
);

  localparam int PW = payload_w(DATA_W, ADDR_W, REG_ADDR_W);

  logic [PW-1:0]         in_payload;
  logic [PW-1:0]         head_payload;
  logic                  head_valid;
  logic                  consume;
  logic [DATA_W-1:0]     h_ins, h_reg1, h_reg2, h_imm, h_csr_rd, h_csr_zimm;
  logic [ADDR_W-1:0]     h_ins_addr, h_csr_addr;
  logic [6:0]            h_opcode, h_funct7;
  logic [2:0]            h_funct3;
  logic [REG_ADDR_W-1:0] h_rd;
  logic                  h_load;
  logic [DATA_W-1:0]     ea_sum;
  logic                  addr_we;
  ld_state_t             ld_state, ld_next;

  assign in_payload = {ins_i, ins_addr_i, opcode_i, funct3_i, funct7_i, reg1_rd_data_i,
                       reg2_rd_data_i, imm_i, reg_wr_addr_i, csr_rd_data_i, csr_zimm_i,
                       csr_rw_addr_i, mem_rd_flag_i};

  assign {h_ins, h_ins_addr, h_opcode, h_funct3, h_funct7, h_reg1, h_reg2, h_imm, h_rd,
          h_csr_rd, h_csr_zimm, h_csr_addr, h_load} = head_payload;

  id_ex_skid #(
    .PAYLOAD_W(PW),
    .SKID_EN  (SKID_EN)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_i),
    .in_valid (id_valid_i),
    .in_ready (id_ready_o),
    .in_data  (in_payload),
    .out_valid(head_valid),
    .out_ready(consume),
    .out_data (head_payload)
  );

  // A load is only offered to EX once its read request has been granted.
  assign ex_valid_o = head_valid && (!h_load || (ld_state == LD_GNTD));
  assign consume    = ex_valid_o && ex_ready_i;

  // Effective address: signed add in data width, then sign-extended or
  // truncated to the address width; overflow simply wraps.
  assign ea_sum  = h_reg1 + h_imm;
  assign addr_we = (ld_state == LD_IDLE) && head_valid && h_load && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state      <= LD_IDLE;
      mem_rd_addr_o <= '0;
    end else begin
      ld_state <= ld_next;
      if (addr_we) mem_rd_addr_o <= ADDR_W'($signed(ea_sum));
    end
  end

  // IDLE only ever sees an unrequested load at the head: leaving GNTD happens
  // on the same edge the granted load leaves the head.
  always_comb begin
    ld_next = ld_state;
    unique case (ld_state)
      LD_IDLE: if (head_valid && h_load) ld_next = LD_REQ;
      LD_REQ:  if (mem_rd_gnt_i) ld_next = LD_GNTD;
      LD_GNTD: if (consume) ld_next = LD_IDLE;
      default: ld_next = LD_IDLE;
    endcase
    // A grant landing with a flush completes on the bus but is not re-requested.
    if (flush_i) ld_next = LD_IDLE;
  end

  assign mem_rd_req_o = (ld_state == LD_REQ);

  always_comb begin
    ins_o          = NOP_INS;
    ins_addr_o     = RESET_ADDR;
    opcode_o       = NOP_OPCODE;
    funct3_o       = '0;
    funct7_o       = '0;
    reg1_rd_data_o = '0;
    reg2_rd_data_o = '0;
    imm_o          = '0;
    reg_wr_addr_o  = '0;
    csr_rd_data_o  = '0;
    csr_zimm_o     = '0;
    csr_rw_addr_o  = '0;
    if (ex_valid_o) begin
      ins_o          = h_ins;
      ins_addr_o     = h_ins_addr;
      opcode_o       = h_opcode;
      funct3_o       = h_funct3;
      funct7_o       = h_funct7;
      reg1_rd_data_o = h_reg1;
      reg2_rd_data_o = h_reg2;
      imm_o          = h_imm;
      reg_wr_addr_o  = h_rd;
      csr_rd_data_o  = h_csr_rd;
      csr_zimm_o     = h_csr_zimm;
      csr_rw_addr_o  = h_csr_addr;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe against a queue-based reference model
module tb_id_ex_pipe;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] ins_addr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] csr_rd;
    logic [31:0] csr_zimm;
    logic [31:0] csr_addr;
    logic        load;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst, flush_i, id_valid_i, id_ready_o, ex_valid_o, ex_ready_i;
  logic        mem_rd_flag_i, mem_rd_req_o, mem_rd_gnt_i;
  logic [31:0] ins_i, ins_addr_i, reg1_rd_data_i, reg2_rd_data_i, imm_i;
  logic [31:0] csr_rd_data_i, csr_zimm_i, csr_rw_addr_i;
  logic [6:0]  opcode_i, funct7_i, opcode_o, funct7_o;
  logic [2:0]  funct3_i, funct3_o;
  logic [4:0]  reg_wr_addr_i, reg_wr_addr_o;
  logic [31:0] ins_o, ins_addr_o, reg1_rd_data_o, reg2_rd_data_o, imm_o;
  logic [31:0] csr_rd_data_o, csr_zimm_o, csr_rw_addr_o, mem_rd_addr_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: entries held by the stage, oldest first.
  txn_t        q[$];
  bit          issued;     // head load has had its request launched
  bit          granted;    // head load has been granted
  logic [31:0] last_addr;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .ins_i(ins_i), .ins_addr_i(ins_addr_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .funct7_i(funct7_i), .reg1_rd_data_i(reg1_rd_data_i), .reg2_rd_data_i(reg2_rd_data_i),
    .imm_i(imm_i), .reg_wr_addr_i(reg_wr_addr_i), .csr_rd_data_i(csr_rd_data_i),
    .csr_zimm_i(csr_zimm_i), .csr_rw_addr_i(csr_rw_addr_i), .mem_rd_flag_i(mem_rd_flag_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ins_o(ins_o), .ins_addr_o(ins_addr_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .reg1_rd_data_o(reg1_rd_data_o), .reg2_rd_data_o(reg2_rd_data_o),
    .imm_o(imm_o), .reg_wr_addr_o(reg_wr_addr_o), .csr_rd_data_o(csr_rd_data_o),
    .csr_zimm_o(csr_zimm_o), .csr_rw_addr_o(csr_rw_addr_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_gnt_i(mem_rd_gnt_i)
  );

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t rand_txn(input bit ld);
    txn_t t;
    t.ins      = $urandom;
    t.ins_addr = $urandom;
    t.opcode   = 7'($urandom);
    t.funct3   = 3'($urandom);
    t.funct7   = 7'($urandom);
    t.reg1     = $urandom;
    t.reg2     = $urandom;
    t.imm      = $urandom;
    t.rd       = 5'($urandom);
    t.csr_rd   = $urandom;
    t.csr_zimm = $urandom;
    t.csr_addr = $urandom;
    t.load     = ld;
    return t;
  endfunction

  function automatic txn_t bubble();
    txn_t b = '0;
    b.ins    = 32'h0000_0013;
    b.opcode = 7'b0010011;
    return b;
  endfunction

  // One clock: compare outputs with the model, drive inputs, advance the model.
  task automatic cycle(input bit v, input txn_t t, input bit rdy, input bit g,
                       input bit fl, input bit rs);
    bit   have, exp_ready, exp_ev, exp_req;
    txn_t h, obs, exp;
    have      = (q.size() > 0);
    h         = have ? q[0] : '0;
    exp_ready = (q.size() < 2);
    exp_ev    = have && (!h.load || granted);
    exp_req   = have && h.load && issued && !granted;
    obs = '{ins:ins_o, ins_addr:ins_addr_o, opcode:opcode_o, funct3:funct3_o,
            funct7:funct7_o, reg1:reg1_rd_data_o, reg2:reg2_rd_data_o, imm:imm_o,
            rd:reg_wr_addr_o, csr_rd:csr_rd_data_o, csr_zimm:csr_zimm_o,
            csr_addr:csr_rw_addr_o, load:1'b0};
    exp = exp_ev ? h : bubble();
    exp.load = 1'b0;
    chk("ex_valid", 320'(ex_valid_o), 320'(exp_ev));
    chk("id_ready", 320'(id_ready_o), 320'(exp_ready));
    chk("mem_req", 320'(mem_rd_req_o), 320'(exp_req));
    chk("mem_addr", 320'(mem_rd_addr_o), 320'(last_addr));
    chk("fields", 320'(obs), 320'(exp));

    id_valid_i = v;  ex_ready_i = rdy;  mem_rd_gnt_i = g;  flush_i = fl;  rst = rs;
    ins_i = t.ins;  ins_addr_i = t.ins_addr;  opcode_i = t.opcode;  funct3_i = t.funct3;
    funct7_i = t.funct7;  reg1_rd_data_i = t.reg1;  reg2_rd_data_i = t.reg2;  imm_i = t.imm;
    reg_wr_addr_i = t.rd;  csr_rd_data_i = t.csr_rd;  csr_zimm_i = t.csr_zimm;
    csr_rw_addr_i = t.csr_addr;  mem_rd_flag_i = t.load;

    @(posedge clk);
    if (rs || fl) begin
      q.delete();
      issued  = 0;
      granted = 0;
      if (rs) last_addr = '0;
    end else begin
      // A load's request is launched one cycle after it reaches the head.
      if (have && h.load && !issued) begin
        issued    = 1;
        last_addr = h.reg1 + h.imm;
      end else if (g && exp_req) begin
        granted = 1;
      end
      if (rdy && exp_ev) begin
        void'(q.pop_front());
        issued  = 0;
        granted = 0;
      end
      if (v && exp_ready) q.push_back(t);
    end
    @(negedge clk);
  endtask

  initial begin
    txn_t t;
    txn_t none;
    none = '0;
    issued = 0;  granted = 0;  last_addr = '0;
    rst = 1'b1;  flush_i = 1'b0;  id_valid_i = 1'b0;  ex_ready_i = 1'b0;  mem_rd_gnt_i = 1'b0;
    ins_i = '0;  ins_addr_i = '0;  opcode_i = '0;  funct3_i = '0;  funct7_i = '0;
    reg1_rd_data_i = '0;  reg2_rd_data_i = '0;  imm_i = '0;  reg_wr_addr_i = '0;
    csr_rd_data_i = '0;  csr_zimm_i = '0;  csr_rw_addr_i = '0;  mem_rd_flag_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_ins", 320'(ins_o), 320'(32'h13));
    chk("rst_opcode", 320'(opcode_o), 320'(7'h13));
    chk("rst_ex_valid", 320'(ex_valid_o), 320'(1'b0));
    chk("rst_id_ready", 320'(id_ready_o), 320'(1'b1));
    chk("rst_req", 320'(mem_rd_req_o), 320'(1'b0));
    cycle(0, none, 1, 0, 0, 0);

    // Stream of 8 ALU ops at full rate
    for (int i = 0; i < 8; i++) cycle(1, rand_txn(0), 1, 0, 0, 0);
    repeat (2) cycle(0, none, 1, 0, 0, 0);

    // Stall: EX not ready for 3 cycles while ID keeps offering
    for (int i = 0; i < 3; i++) cycle(1, rand_txn(0), 0, 0, 0, 0);
    chk("stall_id_ready", 320'(id_ready_o), 320'(1'b0));
    repeat (3) cycle(0, none, 1, 0, 0, 0);

    // Load with wrapping address, grant after 3 requesting cycles
    t = rand_txn(1);
    t.reg1 = 32'hFFFF_FFF0;
    t.imm  = 32'h0000_0020;
    cycle(1, t, 1, 0, 0, 0);
    cycle(0, none, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_addr", 320'(mem_rd_addr_o), 320'(32'h10));
      chk("ld_req_held", 320'(mem_rd_req_o), 320'(1'b1));
      chk("ld_no_valid", 320'(ex_valid_o), 320'(1'b0));
      cycle(0, none, 1, 0, 0, 0);
    end
    cycle(0, none, 1, 1, 0, 0);
    chk("ld_valid_after_gnt", 320'(ex_valid_o), 320'(1'b1));
    repeat (2) cycle(0, none, 1, 0, 0, 0);

    // Flush with both entries full and a simultaneous accept
    cycle(1, rand_txn(0), 0, 0, 0, 0);
    cycle(1, rand_txn(0), 0, 0, 0, 0);
    cycle(1, rand_txn(0), 1, 0, 1, 0);
    chk("flush_ex_valid", 320'(ex_valid_o), 320'(1'b0));
    chk("flush_id_ready", 320'(id_ready_o), 320'(1'b1));
    chk("flush_ins", 320'(ins_o), 320'(32'h13));
    chk("flush_req", 320'(mem_rd_req_o), 320'(1'b0));
    cycle(0, none, 1, 0, 0, 0);

    // Flush coincident with grant: no re-request
    cycle(1, rand_txn(1), 1, 0, 0, 0);
    cycle(0, none, 1, 0, 0, 0);
    cycle(0, none, 1, 1, 1, 0);
    chk("flush_gnt_req", 320'(mem_rd_req_o), 320'(1'b0));
    repeat (2) cycle(0, none, 1, 0, 0, 0);

    // Reset while requesting
    cycle(1, rand_txn(1), 1, 0, 0, 0);
    cycle(0, none, 1, 0, 0, 0);
    cycle(0, none, 1, 0, 0, 1);
    chk("rst_mid_req", 320'(mem_rd_req_o), 320'(1'b0));
    cycle(0, none, 1, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, rand_txn(($urandom % 3) == 0), ($urandom % 3) != 0,
            ($urandom % 2) == 1, ($urandom % 40) == 0, ($urandom % 150) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
